eb_credit_tx: RTL



---
 rtl/eb_credit_tx_pkg.sv | 15 +
 rtl/eb_credit_tx_if.sv | 22 ++
 rtl/eb_credit_tx_counter.sv | 38 +++
 rtl/eb_credit_tx.sv | 97 +++++++++
 4 files changed

// File: rtl/eb_credit_tx_pkg.sv
// Shared types and helpers for the credit-flowed elastic link transmitter.
package eb_pkg;

   typedef enum logic [1:0] {
      ACTIVE,
      DRAIN,
      QUIESCED
   } eb_credit_state_t;

   // Counter width able to hold 0..credits inclusive.
   function automatic int unsigned eb_cwidth(input int unsigned credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/eb_credit_tx_if.sv
// Upstream valid/ready stream plus link beat/credit signals of the elastic link.
interface eb_credit_tx_if #(
   parameter int unsigned DWIDTH = 32
);
   logic [DWIDTH-1:0] t_data;
   logic              t_valid;
   logic              t_ready;
   logic [DWIDTH-1:0] i_data;
   logic              i_valid;
   logic              i_credit;

   // master is the transmitter, slave is its environment
   modport master (
      input  t_data, t_valid, i_credit,
      output t_ready, i_data, i_valid
   );

   modport slave (
      output t_data, t_valid, i_credit,
      input  t_ready, i_data, i_valid
   );
endinterface

// File: rtl/eb_credit_tx_counter.sv
// Saturating up/down credit counter; resets full, never exceeds CREDITS.
module eb_credit_counter
   import eb_pkg::*;
#(
   parameter int unsigned CREDITS = 4
) (
   input  logic                           clk,
   input  logic                           rstf,
   input  logic                           inc,
   input  logic                           dec,
   output logic [eb_cwidth(CREDITS)-1:0]  cnt,
   output logic                           full,
   output logic                           nxt_full
);
   localparam int unsigned CWIDTH = eb_cwidth(CREDITS);
   localparam logic [CWIDTH-1:0] MAX = CWIDTH'(CREDITS);

   logic [CWIDTH-1:0] nxt;

   assign full = (cnt == MAX);

   always_comb begin
      nxt = cnt;
      if (dec && !inc)
         nxt = cnt - CWIDTH'(1);
      else if (inc && !dec && !full)
         nxt = cnt + CWIDTH'(1);
   end

   assign nxt_full = (nxt == MAX);

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf)
         cnt <= MAX;
      else
         cnt <= nxt;
   end
endmodule

// File: rtl/eb_credit_tx.sv
// Transmit end of a credit-flowed elastic link with quiesce/drain handshake.
// Optional sticky err output is built when EB_CREDIT_TX_ERR_EN is defined.
module eb_credit_tx
   import eb_pkg::*;
#(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned CREDITS = 4
) (
   input  logic                           clk,
   input  logic                           rstf,
   eb_credit_tx_if.master                 bus,
   input  logic                           quiesce_req,
   output logic                           quiesce_ack,
`ifdef EB_CREDIT_TX_ERR_EN
   output logic                           err,
`endif
   output logic [eb_cwidth(CREDITS)-1:0]  credit_cnt
);
   eb_credit_state_t  state;
   logic [DWIDTH-1:0] data_q;
   logic              valid_q;
   logic              accept;
   logic              full;
   logic              nxt_full;

   // Ready decodes from registered state only.
   assign bus.t_ready = (state == ACTIVE) && (credit_cnt != '0);
   assign accept      = bus.t_valid && bus.t_ready;
   assign bus.i_valid = valid_q;
   assign bus.i_data  = data_q;

   eb_credit_counter #(
      .CREDITS (CREDITS)
   ) u_cnt (
      .clk      (clk),
      .rstf     (rstf),
      .inc      (bus.i_credit),
      .dec      (accept),
      .cnt      (credit_cnt),
      .full     (full),
      .nxt_full (nxt_full)
   );

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= accept;
         if (accept)
            data_q <= bus.t_data;
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         state       <= ACTIVE;
         quiesce_ack <= 1'b0;
      end else begin
         case (state)
            ACTIVE: begin
               if (quiesce_req)
                  state <= DRAIN;
            end
            DRAIN: begin
               // Abort takes priority over completing the drain.
               if (!quiesce_req) begin
                  state <= ACTIVE;
               end else if (nxt_full) begin
                  state       <= QUIESCED;
                  quiesce_ack <= 1'b1;
               end
            end
            QUIESCED: begin
               if (!quiesce_req) begin
                  state       <= ACTIVE;
                  quiesce_ack <= 1'b0;
               end
            end
            default: begin
               state       <= ACTIVE;
               quiesce_ack <= 1'b0;
            end
         endcase
      end
   end

`ifdef EB_CREDIT_TX_ERR_EN
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf)
         err <= 1'b0;
      else if ((bus.i_credit && full && !accept) ||
               (bus.i_credit && state == QUIESCED))
         err <= 1'b1;
   end
`endif
endmodule
